data_memory_bytelane: RTL and testbench
=======================================

Name: data_memory_bytelane

Overview:
Parametrised data memory with byte lanes for the RV32 load/store path. Supports LB/LBU/LH/LHU/LW and SB/SH/SW with sign or zero extension, a registered read with REQ/READY/VALID handshake, and range/size error reporting. After reset it runs a hardware zero-fill sequence, so memory contents are deterministic. Sits between the core's memory stage and the word array.

Parameters:
DEPTH, 32, number of 32-bit words; any value from 2 to 4096.
ADDR_W, 32, width of byte address A.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  reset, asynchronous, active-low.
REQ  input  1  access request; sampled when READY=1.
WE  input  1  1 = store, 0 = load.
SIZE  input  2  00 byte, 01 half, 10 word, 11 reserved.
UNS  input  1  loads only; 1 = zero-extend, 0 = sign-extend.
A  input  ADDR_W  byte address.
WD  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
READY  output  1  1 = request accepted this cycle if REQ=1.
VALID  output  1  one-cycle response strobe.
RD  output  32  load result, extended; 0 for stores and errors.
ERR  output  1  error flag; qualified by VALID.

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous and active-low.
- Reset values (asynchronous): READY=0, VALID=0, RD=0, ERR=0. Clear counter=0, state=CLEAR.
- CLEAR state:
  - Writes word[cnt]=0 each cycle for cnt=0..DEPTH-1, i.e. DEPTH cycles.
  - Then moves to IDLE; READY=1 from the next cycle.
  - REQ is ignored during CLEAR and produces no response.
- IDLE state:
  - READY=1 continuously; one request is accepted per cycle (full throughput).
  - Response appears 1 cycle after accept: VALID=1 for exactly that cycle, with RD and ERR valid.
  - With no accept, VALID=0 and RD/ERR hold their previous values.
- Word index = A[ADDR_W-1:2].
  - Index >= DEPTH gives ERR=1, RD=0, no write, no aliasing.
  - SIZE=11 gives ERR=1, RD=0, no write.
- Store lane enables:
  - SB: lane A[1:0] gets WD[7:0].
  - SH: lanes {A[1],0} and {A[1],1} get WD[15:0].
  - SW: all four lanes get WD.
  - Unselected lanes are unchanged.
  - The write commits on the accept edge.
- Load:
  - The word is read on the accept edge; the addressed byte/half is extracted and shifted to bit 0.
  - Extended per UNS. LW ignores UNS.
- Back-to-back hazard: a store accepted in cycle n followed by a load of the same word in cycle n+1 returns the new data. No stale read is permitted.
- Reset mid-operation: any in-flight response is dropped (VALID falls immediately) and CLEAR restarts; all memory is zeroed again.
- Contents persist across a CLEAR only in the sense that they are overwritten with 0. No other initialisation exists.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half access with A[0]=1, or a word access with A[1:0]!=00, gives ERR=1, RD=0, no write.
- Undefined: low address bits are forced to natural alignment (half ignores A[0], word ignores A[1:0]). Such accesses complete normally with ERR=0.

Test Plan:
- Zero-fill after reset: release RST_N -> READY=0 for exactly 32 cycles, then 1. LW 0x7C -> VALID next cycle, RD=0x00000000, ERR=0.
- Loads after SW 0x10, WD=0x8899AABB:
  - LB 0x13 -> RD=0xFFFFFF88
  - LBU 0x12 -> RD=0x00000099
  - LH 0x10 -> RD=0xFFFFAABB
  - LHU 0x12 -> RD=0x00008899
- Byte-lane store: SB 0x11, WD=0x12345677 -> LW 0x10 returns 0x889977BB. SH 0x12, WD=0x0000CAFE -> LW 0x10 returns 0xCAFE77BB.
- Out of range: SW 0x80, WD=0xDEADBEEF -> ERR=1, RD=0. LW 0x00 -> 0x00000000 (no alias). SIZE=11 at 0x10 -> ERR=1, no write.
- Misalignment: LW 0x12 after the store scenario -> with MISALIGN_TRAP_EN, ERR=1 and RD=0; without it, RD=0xCAFE77BB and ERR=0.
- Reset mid-stream:
  - Stream SW/LW every cycle and assert RST_N=0 between edges -> VALID=0 immediately.
  - After release, READY=0 for 32 cycles.
  - LW 0x10 -> 0x00000000.

Source files
------------

// File: rtl/data_memory_bytelane.sv
// Byte-lane RV32 data memory: LB/LBU/LH/LHU/LW, SB/SH/SW, registered read, hardware zero-fill after reset.
// Optional: MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of force-aligning them.
module data_memory_bytelane #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       wd,
  output logic              ready,
  output logic              valid,
  output logic [31:0]       rd,
  output logic              err
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IDX_W  = ADDR_W - 2;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state, state_nxt;
  logic [MEM_AW-1:0] cnt;
  logic              clr_en_c, ready_nxt_c;
  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  idx_c;
  logic [MEM_AW-1:0] mem_addr_c;
  logic              in_range_c, misalign_c, ok_c, accept_c;
  logic [1:0]        off_c;
  logic [31:0]       rword_c, shifted_c, load_c, wlane_c;
  logic [3:0]        be_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  // Next state: leave CLEAR once the last word has been zeroed
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (cnt == MEM_AW'(DEPTH - 1)) state_nxt = ST_IDLE;
      ST_IDLE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    clr_en_c    = 1'b0;
    ready_nxt_c = 1'b0;
    if (state == ST_CLEAR)    clr_en_c    = 1'b1;
    if (state_nxt == ST_IDLE) ready_nxt_c = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      if (clr_en_c) cnt <= cnt + MEM_AW'(1);
      ready <= ready_nxt_c;
    end
  end

  // Address decode, range and alignment
  always_comb begin
    idx_c      = a[ADDR_W-1:2];
    mem_addr_c = idx_c[MEM_AW-1:0];
    in_range_c = 64'(idx_c) < 64'(DEPTH);
`ifdef MISALIGN_TRAP_EN
    misalign_c = ((size == 2'b01) && a[0]) || ((size == 2'b10) && (a[1:0] != 2'b00));
    off_c      = a[1:0];
`else
    misalign_c = 1'b0;
    case (size)
      2'b01:   off_c = {a[1], 1'b0};
      2'b10:   off_c = 2'b00;
      default: off_c = a[1:0];
    endcase
`endif
    ok_c     = in_range_c && (size != 2'b11) && !misalign_c;
    accept_c = ready && req;
  end

  // Load extraction and store lane steering
  always_comb begin
    rword_c   = mem[mem_addr_c];
    shifted_c = rword_c >> {off_c, 3'b000};
    case (size)
      2'b00: begin
        load_c  = uns ? {24'h0, shifted_c[7:0]} : {{24{shifted_c[7]}}, shifted_c[7:0]};
        wlane_c = {4{wd[7:0]}};
        be_c    = 4'b0001 << off_c;
      end
      2'b01: begin
        load_c  = uns ? {16'h0, shifted_c[15:0]} : {{16{shifted_c[15]}}, shifted_c[15:0]};
        wlane_c = {2{wd[15:0]}};
        be_c    = off_c[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_c  = shifted_c;
        wlane_c = wd;
        be_c    = 4'b1111;
      end
    endcase
  end

  // Word array: zero-fill during CLEAR, lane-masked store on accept
  always_ff @(posedge clk) begin
    if (clr_en_c) begin
      mem[cnt] <= 32'h0;
    end else if (accept_c && we && ok_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[mem_addr_c][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
  end

  // Registered response; RD/ERR hold when nothing is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rd    <= 32'h0;
      err   <= 1'b0;
    end else begin
      valid <= accept_c;
      if (accept_c) begin
        rd  <= (ok_c && !we) ? load_c : 32'h0;
        err <= !ok_c;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Randomized self-checking bench for data_memory_bytelane against a byte-array reference model.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_data_memory_bytelane;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] a = 32'h0, wd = 32'h0;
  logic        ready, valid, err;
  logic [31:0] rd;

  always #5 clk = ~clk;

  data_memory_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .a(a), .wd(wd), .ready(ready), .valid(valid), .rd(rd), .err(err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  model [DEPTH*4];
  logic        pend = 1'b0;
  string       ptag = "";
  logic [31:0] exp_rd = 32'h0;
  logic        exp_err = 1'b0;
  logic        chk_lit = 1'b0;
  logic [31:0] lit = 32'h0;
  logic [31:0] last_rd = 32'h0;
  logic        last_err = 1'b0;

`ifdef MISALIGN_TRAP_EN
  localparam logic [31:0] LW12_RD = 32'h0;
`else
  localparam logic [31:0] LW12_RD = 32'hCAFE77BB;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, expv);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH*4; i++) model[i] = 8'h00;
  endfunction

  // Reference: memory as a flat byte array, accesses as little-endian byte runs
  task automatic model_access(input logic w, input logic [1:0] sz, input logic u,
                              input logic [31:0] ad, input logic [31:0] d,
                              output logic [31:0] r, output logic e);
    int unsigned nb;
    logic [31:0] base, v, ext;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e  = (sz == 2'd3) || ((ad >> 2) >= DEPTH);
`ifdef MISALIGN_TRAP_EN
    if (sz != 2'd3 && (ad % nb) != 0) e = 1'b1;
    base = ad;
`else
    base = ad - (ad % nb);
`endif
    r = 32'h0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < int'(nb); i++) model[base + 32'(i)] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < int'(nb); i++) v = v | (32'(model[base + 32'(i)]) << (8*i));
        ext = 32'hFFFF_FFFF;
        if (!u && nb < 4 && v[8*nb-1]) v = v | (ext << (8*nb));
        r = v;
      end
    end
  endtask

  // One clock: check the response due now, then drive the next request
  task automatic step(input string tag, input logic r, input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] ad, input logic [31:0] d,
                      input logic cl, input logic [31:0] lv);
    @(negedge clk);
    if (pend) begin
      check_eq({ptag, "/valid"}, 32'(valid), 32'd1);
      check_eq({ptag, "/rd"}, rd, exp_rd);
      check_eq({ptag, "/err"}, 32'(err), 32'(exp_err));
      if (chk_lit) check_eq({ptag, "/plan_rd"}, rd, lit);
      last_rd  = exp_rd;
      last_err = exp_err;
    end else begin
      check_eq("idle/valid", 32'(valid), 32'd0);
      check_eq("idle/rd_hold", rd, last_rd);
      check_eq("idle/err_hold", 32'(err), 32'(last_err));
    end
    check_eq("ready", 32'(ready), 32'd1);
    req = r; we = w; size = sz; uns = u; a = ad; wd = d;
    pend = r; ptag = tag; chk_lit = cl; lit = lv;
    if (r) model_access(w, sz, u, ad, d, exp_rd, exp_err);
  endtask

  // After reset release: REQ is ignored while the array is being zeroed
  task automatic wait_clear();
    int n;
    n = 0;
    req = 1'b1; we = 1'b1; size = 2'd2; a = 32'h10; wd = 32'hFFFF_FFFF;
    do begin
      @(posedge clk); #1;
      n++;
      if (!ready) check_eq("clear/valid", 32'(valid), 32'd0);
    end while (!ready && n < 200);
    req = 1'b0;
    check_eq("clear/len", 32'(n), 32'(DEPTH));
    pend = 1'b0; last_rd = 32'h0; last_err = 1'b0;
    model_clear();
  endtask

  task automatic rand_step();
    logic        r, w;
    logic [1:0]  sz;
    logic [31:0] ad;
    r  = ($urandom_range(0, 9) != 0);
    w  = 1'($urandom_range(0, 1));
    sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    ad = $urandom_range(0, 1) ? 32'($urandom_range(0, 31)) : 32'($urandom_range(0, DEPTH*4 + 15));
    step("rand", r, w, sz, 1'($urandom_range(0, 1)), ad, $urandom, 1'b0, 32'h0);
  endtask

  initial begin
    #1;
    check_eq("rst/ready", 32'(ready), 32'd0);
    check_eq("rst/valid", 32'(valid), 32'd0);
    check_eq("rst/rd", rd, 32'h0);
    check_eq("rst/err", 32'(err), 32'd0);
    #20;
    @(negedge clk); rst_n = 1'b1;
    wait_clear();

    step("lw7c",  1, 0, 2'd2, 0, 32'h7C, 32'h0,         1, 32'h0);
    step("sw10",  1, 1, 2'd2, 0, 32'h10, 32'h8899AABB,  1, 32'h0);
    step("lb13",  1, 0, 2'd0, 0, 32'h13, 32'h0,         1, 32'hFFFFFF88);
    step("lbu12", 1, 0, 2'd0, 1, 32'h12, 32'h0,         1, 32'h00000099);
    step("lh10",  1, 0, 2'd1, 0, 32'h10, 32'h0,         1, 32'hFFFFAABB);
    step("lhu12", 1, 0, 2'd1, 1, 32'h12, 32'h0,         1, 32'h00008899);
    step("sb11",  1, 1, 2'd0, 0, 32'h11, 32'h12345677,  1, 32'h0);
    step("lw10a", 1, 0, 2'd2, 0, 32'h10, 32'h0,         1, 32'h889977BB);
    step("sh12",  1, 1, 2'd1, 0, 32'h12, 32'h0000CAFE,  1, 32'h0);
    step("lw10b", 1, 0, 2'd2, 0, 32'h10, 32'h0,         1, 32'hCAFE77BB);
    step("sw80",  1, 1, 2'd2, 0, 32'h80, 32'hDEADBEEF,  1, 32'h0);
    step("lw00",  1, 0, 2'd2, 0, 32'h00, 32'h0,         1, 32'h0);
    step("sz3",   1, 1, 2'd3, 0, 32'h10, 32'h11111111,  1, 32'h0);
    step("lw10c", 1, 0, 2'd2, 0, 32'h10, 32'h0,         1, 32'hCAFE77BB);
    step("lw12",  1, 0, 2'd2, 0, 32'h12, 32'h0,         1, LW12_RD);
    step("idle",  0, 0, 2'd0, 0, 32'h0,  32'h0,         0, 32'h0);
    step("lwhi",  1, 0, 2'd2, 0, 32'hFFFFFFFC, 32'h0,   1, 32'h0);
    step("idle",  0, 0, 2'd0, 0, 32'h0,  32'h0,         0, 32'h0);

    for (int i = 0; i < 400; i++) rand_step();

    // Reset in the middle of a full-rate store/load stream
    for (int i = 0; i < 8; i++)
      step("stream", 1, 1'(i % 2), 2'd2, 0, 32'h10, $urandom, 1'b0, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b0; req = 1'b0;
    #1;
    check_eq("midrst/valid", 32'(valid), 32'd0);
    check_eq("midrst/ready", 32'(ready), 32'd0);
    check_eq("midrst/rd", rd, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    wait_clear();
    step("lw10z", 1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 32'h0);
    for (int i = 0; i < 200; i++) rand_step();
    step("idle", 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);
    step("idle", 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
